// File: rtl/jtframe_rom_pkg.sv
// Shared definitions for the ROM round-robin arbiter: FSM states and burst size.
package jtframe_rom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    // Each cache miss fetches this many 16-bit words (one 32-bit cache entry)
    localparam int BURST_LEN = 2;

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: returns the first requester after 'last',
// wrapping from SW-1 back to 0, and whether any requester is active.
module jtframe_rr_pick #(
    parameter int SW = 4,
    parameter int IW = $clog2(SW)
) (
    input  logic [SW-1:0] req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt,
    output logic          any
);

    logic [IW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester after 'last' wins
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int i = SW; i >= 1; i--) begin
            idx = IW'((int'(last) + i) % SW);
            if (req[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_rom_rrarb.sv
// Round-robin arbiter sharing one SDRAM bank read port among SW ROM slots.
// Every slot keeps a one-entry 32-bit cache; each miss becomes a 2-word burst.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no fetch in flight, pick the next pending slot
// REQ     | sdram_rd held high until the controller acks
// WAIT    | request accepted, waiting for the first data word (dst)
// DATA    | second word on the bus, write the cache entry of slot g
module jtframe_rom_rrarb
    import jtframe_rom_pkg::*;
#(
    parameter int               SW      = 4,
    parameter int               SAW     = 12,
    parameter int               AW      = 22,
    parameter logic [SW*AW-1:0] OFFSETS = '0
) (
    input  logic               rst,
    input  logic               clk,
    input  logic               flush,
    input  logic [SW-1:0]      slot_cs,
    input  logic [SW*SAW-1:0]  slot_addr,
    output logic [SW-1:0]      slot_ok,
    output logic [SW*32-1:0]   slot_dout,
    output logic               sdram_rd,
    output logic [AW-1:0]      sdram_addr,
    input  logic               sdram_ack,
    input  logic               data_dst,
    input  logic               data_rdy,
    input  logic [15:0]        data_read
);

    localparam int IW = $clog2(SW);
    localparam int DW = 16 * BURST_LEN;

    state_t         state;
    logic [IW-1:0]  g;
    logic [IW-1:0]  rr;
    logic [SAW-1:0] addr_l;
    logic [15:0]    low;

    logic [SAW-1:0] addr_a [SW];
    logic [AW-1:0]  off_a  [SW];
    logic [SW-1:0]  valid;
    logic [SW-1:0]  hit;
    logic [SW-1:0]  pending;
    logic [IW-1:0]  pick_gnt;
    logic           pick_any;
    logic           busy;
    logic           fill;

    assign busy = (state != ST_IDLE);
    // rdy in DATA completes the burst; anything else leaves the cache alone
    assign fill = (state == ST_DATA) && data_rdy;

    for (genvar n = 0; n < SW; n++) begin : g_slot
        logic [SAW-1:0] cached_addr;
        logic [DW-1:0]  cache_data;
        logic           valid_r;

        assign addr_a[n] = slot_addr[n*SAW +: SAW];
        assign off_a[n]  = OFFSETS[n*AW +: AW];

        // Cache entry update: a fill of this slot writes data/address; flush overrides valid
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cached_addr <= '0;
                cache_data  <= '0;
                valid_r     <= 1'b0;
            end else begin
                if (fill && g == IW'(n)) begin
                    cached_addr <= addr_l;
                    cache_data  <= {data_read, low};
                    valid_r     <= 1'b1;
                end
                if (flush) begin
                    valid_r <= 1'b0;
                end
            end
        end

        assign valid[n]   = valid_r;
        assign hit[n]     = valid_r && (cached_addr == addr_a[n]);
        assign slot_ok[n] = slot_cs[n] && hit[n];
        assign slot_dout[n*32 +: 32] = cache_data;
        // The slot already being fetched must not be granted a second time
        assign pending[n] = slot_cs[n] && !hit[n] && !(busy && g == IW'(n));
    end

    jtframe_rr_pick #(
        .SW   (SW),
        .IW   (IW)
    ) u_pick (
        .req  (pending),
        .last (rr),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    // Fetch sequencer: grant, hold the request until ack, then collect the two-word burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            g          <= '0;
            rr         <= IW'(SW - 1);
            addr_l     <= '0;
            low        <= '0;
            sdram_rd   <= 1'b0;
            sdram_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        g          <= pick_gnt;
                        rr         <= pick_gnt;
                        addr_l     <= addr_a[pick_gnt];
                        sdram_rd   <= 1'b1;
                        sdram_addr <= off_a[pick_gnt] + AW'({addr_a[pick_gnt], 1'b0});
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        sdram_rd <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_dst) begin
                        low   <= data_read;
                        state <= ST_DATA;
                    end else if (data_rdy) begin
                        // rdy without dst is a broken burst: drop it, no fill
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_rom_rrarb.sv
// Directed testbench for jtframe_rom_rrarb with a hand-driven bank controller.
module tb_jtframe_rom_rrarb;

    localparam int SW  = 4;
    localparam int SAW = 12;
    localparam int AW  = 22;
    localparam logic [SW*AW-1:0] OFFS = {22'h300000, 22'h200000, 22'h100000, 22'h000000};

    logic              rst;
    logic              clk = 1'b0;
    logic              flush;
    logic [SW-1:0]     slot_cs;
    logic [SW*SAW-1:0] slot_addr;
    logic [SW-1:0]     slot_ok;
    logic [SW*32-1:0]  slot_dout;
    logic              sdram_rd;
    logic [AW-1:0]     sdram_addr;
    logic              sdram_ack;
    logic              data_dst;
    logic              data_rdy;
    logic [15:0]       data_read;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtframe_rom_rrarb #(
        .SW         (SW),
        .SAW        (SAW),
        .AW         (AW),
        .OFFSETS    (OFFS)
    ) dut (
        .rst        (rst),
        .clk        (clk),
        .flush      (flush),
        .slot_cs    (slot_cs),
        .slot_addr  (slot_addr),
        .slot_ok    (slot_ok),
        .slot_dout  (slot_dout),
        .sdram_rd   (sdram_rd),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_dst   (data_dst),
        .data_rdy   (data_rdy),
        .data_read  (data_read)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] off(input int s);
        return OFFS[s*AW +: AW];
    endfunction

    // Reference SDRAM content
    function automatic logic [15:0] word(input logic [AW-1:0] a);
        return a[15:0] ^ {a[21:16], 10'h000} ^ 16'hC3A5;
    endfunction

    function automatic logic [AW-1:0] base(input int s, input logic [SAW-1:0] a);
        return off(s) + AW'({a, 1'b0});
    endfunction

    function automatic logic [31:0] exp_dout(input int s, input logic [SAW-1:0] a);
        logic [AW-1:0] b;
        b = base(s, a);
        return {word(b + AW'(1)), word(b)};
    endfunction

    task automatic set_slot(input int s, input logic cs, input logic [SAW-1:0] a);
        slot_cs[s] = cs;
        slot_addr[s*SAW +: SAW] = a;
    endtask

    task automatic apply_reset;
        rst       = 1'b1;
        flush     = 1'b0;
        slot_cs   = '0;
        slot_addr = '0;
        sdram_ack = 1'b0;
        data_dst  = 1'b0;
        data_rdy  = 1'b0;
        data_read = '0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
    endtask

    // Wait (bounded) for sdram_rd, check the address and acknowledge
    task automatic serve_req(input logic [AW-1:0] exp_addr, input string name);
        int n;
        n = 0;
        while (sdram_rd !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (sdram_rd !== 1'b1) begin
            failures++;
            $display("FAIL %s rd_timeout got=%b exp=1", name, sdram_rd);
            return;
        end
        checks++;
        if (sdram_addr !== exp_addr) begin
            failures++;
            $display("FAIL %s addr got=%h exp=%h", name, sdram_addr, exp_addr);
        end
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        checks++;
        if (sdram_rd !== 1'b0) begin
            failures++;
            $display("FAIL %s rd_drop got=%b exp=0", name, sdram_rd);
        end
    endtask

    // dst with low word, then rdy with high word (optionally flush during the DATA cycle)
    task automatic serve_data(input logic [15:0] lo, input logic [15:0] hi, input logic fl);
        data_dst  = 1'b1;
        data_read = lo;
        tick;
        data_dst  = 1'b0;
        data_rdy  = 1'b1;
        data_read = hi;
        flush     = fl;
        tick;
        data_rdy  = 1'b0;
        flush     = 1'b0;
        data_read = '0;
    endtask

    task automatic serve(input int s, input logic [SAW-1:0] a, input string name);
        logic [AW-1:0] b;
        b = base(s, a);
        serve_req(b, name);
        serve_data(word(b), word(b + AW'(1)), 1'b0);
    endtask

    task automatic test_reset;
        apply_reset;
        checks++;
        if (sdram_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", sdram_rd); end
        checks++;
        if (sdram_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sdram_addr); end
        checks++;
        if (slot_ok !== '0) begin failures++; $display("FAIL reset_ok got=%b exp=0", slot_ok); end
        checks++;
        if (slot_dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", slot_dout); end
    endtask

    task automatic test_single_miss;
        set_slot(0, 1'b1, 12'h010);
        #1;
        checks++;
        if (sdram_rd !== 1'b0 || slot_ok[0] !== 1'b0) begin
            failures++;
            $display("FAIL miss_grant_cycle rd=%b ok=%b exp rd=0 ok=0", sdram_rd, slot_ok[0]);
        end
        tick;
        checks++;
        if (sdram_rd !== 1'b1) begin failures++; $display("FAIL miss_latency rd got=%b exp=1", sdram_rd); end
        serve_req(22'h000020, "miss");
        serve_data(16'h1234, 16'h5678, 1'b0);
        checks++;
        if (slot_ok[0] !== 1'b1) begin failures++; $display("FAIL miss_ok got=%b exp=1", slot_ok[0]); end
        checks++;
        if (slot_dout[31:0] !== 32'h56781234) begin
            failures++;
            $display("FAIL miss_dout got=%h exp=56781234", slot_dout[31:0]);
        end
    endtask

    task automatic test_hit;
        set_slot(0, 1'b0, 12'h010);
        tick;
        checks++;
        if (slot_ok[0] !== 1'b0) begin failures++; $display("FAIL hit_cs_low ok got=%b exp=0", slot_ok[0]); end
        set_slot(0, 1'b1, 12'h010);
        #1;
        checks++;
        if (slot_ok[0] !== 1'b1 || sdram_rd !== 1'b0) begin
            failures++;
            $display("FAIL hit_same_cycle ok=%b rd=%b exp ok=1 rd=0", slot_ok[0], sdram_rd);
        end
        tick;
        checks++;
        if (sdram_rd !== 1'b0) begin failures++; $display("FAIL hit_no_rd got=%b exp=0", sdram_rd); end
        set_slot(0, 1'b0, 12'h000);
        tick;
    endtask

    task automatic test_back_to_back;
        apply_reset;
        for (int s = 0; s < SW; s++) set_slot(s, 1'b1, SAW'(12'h040 + s));
        for (int k = 0; k < SW; k++) serve(k, SAW'(12'h040 + k), $sformatf("rr_slot%0d", k));
        for (int s = 0; s < SW; s++) begin
            checks++;
            if (slot_ok[s] !== 1'b1 || slot_dout[s*32 +: 32] !== exp_dout(s, SAW'(12'h040 + s))) begin
                failures++;
                $display("FAIL rr_fill%0d ok=%b dout=%h exp ok=1 dout=%h", s, slot_ok[s],
                         slot_dout[s*32 +: 32], exp_dout(s, SAW'(12'h040 + s)));
            end
        end
        repeat (3) tick;
        checks++;
        if (sdram_rd !== 1'b0) begin failures++; $display("FAIL rr_extra_grant rd got=%b exp=0", sdram_rd); end
        slot_cs = '0;
        tick;
    endtask

    task automatic test_addr_change;
        logic [AW-1:0] b;
        b = base(2, 12'h100);
        set_slot(2, 1'b1, 12'h100);
        serve_req(b, "chg_first");
        set_slot(2, 1'b1, 12'h101);
        serve_data(word(b), word(b + AW'(1)), 1'b0);
        checks++;
        if (slot_ok[2] !== 1'b0) begin failures++; $display("FAIL chg_ok_stale got=%b exp=0", slot_ok[2]); end
        checks++;
        if (slot_dout[95:64] !== exp_dout(2, 12'h100)) begin
            failures++;
            $display("FAIL chg_old_fill got=%h exp=%h", slot_dout[95:64], exp_dout(2, 12'h100));
        end
        serve_req(22'h200202, "chg_second");
        b = base(2, 12'h101);
        serve_data(word(b), word(b + AW'(1)), 1'b0);
        checks++;
        if (slot_ok[2] !== 1'b1 || slot_dout[95:64] !== exp_dout(2, 12'h101)) begin
            failures++;
            $display("FAIL chg_new_fill ok=%b dout=%h exp ok=1 dout=%h", slot_ok[2], slot_dout[95:64],
                     exp_dout(2, 12'h101));
        end
        slot_cs = '0;
        tick;
    endtask

    task automatic test_flush;
        logic [AW-1:0] b;
        b = base(1, 12'h055);
        set_slot(1, 1'b1, 12'h055);
        serve_req(b, "flush_first");
        serve_data(word(b), word(b + AW'(1)), 1'b1);
        checks++;
        if (slot_ok[1] !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", slot_ok[1]); end
        serve_req(22'h1000AA, "flush_refetch");
        serve_data(word(b), word(b + AW'(1)), 1'b0);
        checks++;
        if (slot_ok[1] !== 1'b1 || slot_dout[63:32] !== exp_dout(1, 12'h055)) begin
            failures++;
            $display("FAIL flush_refill ok=%b dout=%h exp ok=1 dout=%h", slot_ok[1], slot_dout[63:32],
                     exp_dout(1, 12'h055));
        end
        slot_cs = '0;
        tick;
    endtask

    task automatic test_reset_mid_fetch;
        set_slot(3, 1'b1, 12'h007);
        serve_req(base(3, 12'h007), "rst_mid");
        rst = 1'b1;
        #1;
        checks++;
        if (sdram_rd !== 1'b0 || slot_ok !== '0 || slot_dout !== '0 || sdram_addr !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs rd=%b ok=%b dout=%h addr=%h exp all 0", sdram_rd, slot_ok,
                     slot_dout, sdram_addr);
        end
        slot_cs = '0;
        tick;
        rst = 1'b0;
        tick;
        serve_data(16'hDEAD, 16'hBEEF, 1'b0);
        set_slot(3, 1'b1, 12'h007);
        #1;
        checks++;
        if (slot_ok[3] !== 1'b0 || slot_dout[127:96] !== 32'h0) begin
            failures++;
            $display("FAIL rst_stray_dst ok=%b dout=%h exp ok=0 dout=0", slot_ok[3], slot_dout[127:96]);
        end
        serve(3, 12'h007, "rst_refetch");
        checks++;
        if (slot_ok[3] !== 1'b1 || slot_dout[127:96] !== exp_dout(3, 12'h007)) begin
            failures++;
            $display("FAIL rst_refetch_fill ok=%b dout=%h exp ok=1 dout=%h", slot_ok[3], slot_dout[127:96],
                     exp_dout(3, 12'h007));
        end
        slot_cs = '0;
        tick;
    endtask

    task automatic test_random_reads;
        int s;
        logic [SAW-1:0] a;
        for (int it = 0; it < 40; it++) begin
            s = $urandom_range(0, SW - 1);
            a = SAW'($urandom_range(0, 5));
            set_slot(s, 1'b1, a);
            #1;
            if (slot_ok[s] !== 1'b1) serve(s, a, $sformatf("rand%0d", it));
            checks++;
            if (slot_ok[s] !== 1'b1 || slot_dout[s*32 +: 32] !== exp_dout(s, a)) begin
                failures++;
                $display("FAIL rand%0d slot%0d ok=%b dout=%h exp ok=1 dout=%h", it, s, slot_ok[s],
                         slot_dout[s*32 +: 32], exp_dout(s, a));
            end
            set_slot(s, 1'b0, a);
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_single_miss;
        test_hit;
        test_back_to_back;
        test_addr_change;
        test_flush;
        test_reset_mid_fetch;
        test_random_reads;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
